// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer output stage and the alarm stage that
// feeds it: FSM state encoding, channel codes, default timing constants and
// the fixed-priority request arbiter.
package buzzer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_e;

  localparam logic [1:0] CH_NONE = 2'd0;
  localparam logic [1:0] CH1     = 2'd1;
  localparam logic [1:0] CH2     = 2'd2;
  localparam logic [1:0] CH3     = 2'd3;

  localparam int DEF_TONE1_HALF = 12;
  localparam int DEF_TONE2_HALF = 8;
  localparam int DEF_TONE3_HALF = 5;
  localparam int DEF_BEEP_ON    = 64;
  localparam int DEF_BEEP_OFF   = 32;
  localparam int DEF_MIN_BEEPS  = 2;

  // Highest set request index wins; returns the channel code (index+1),
  // or CH_NONE when no request is pending.
  function automatic logic [1:0] win_chan(input logic [2:0] r);
    logic [1:0] c;
    c = CH_NONE;
    if (r[2])      c = CH3;
    else if (r[1]) c = CH2;
    else if (r[0]) c = CH1;
    return c;
  endfunction

endpackage

// File: rtl/buzzer_tone_gen_tone_divider.sv
// tone_divider: half-period counter with a toggle flop.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance the counter this cycle
//   clr        : synchronous clear of counter and output (wins over en)
//   half       : half-period in clk cycles (>= 2)
//   tone_out   : registered square wave, toggles when the counter wraps
module tone_divider #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic [CW-1:0] half,
  output logic          tone_out
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tone_q, tone_d;

  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (clr) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (en) begin
      if (cnt_q == half - CW'(1)) begin
        cnt_d  = '0;
        tone_d = ~tone_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone_out = tone_q;

endmodule

// File: rtl/buzzer_tone_gen.sv
// buzzer_tone_gen: drives the piezo pin with a channel-specific square wave
// gated into an on/off beep cadence. Every alert lasts at least MIN_BEEPS
// beeps; simultaneous requests are resolved by fixed priority (req[2] first).
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : clock enable, low freezes all state
//   req[2:0]   : level requests for channels 3..1
//   tone_out   : square wave to the piezo
//   chan       : latched channel (0 = none, 1..3)
//   beep_cnt   : completed beeps in the current alert, saturating at 15
//   busy       : high whenever an alert is in progress
module buzzer_tone_gen
  import buzzer_pkg::*;
#(
  parameter int TONE1_HALF = DEF_TONE1_HALF,
  parameter int TONE2_HALF = DEF_TONE2_HALF,
  parameter int TONE3_HALF = DEF_TONE3_HALF,
  parameter int BEEP_ON    = DEF_BEEP_ON,
  parameter int BEEP_OFF   = DEF_BEEP_OFF,
  parameter int MIN_BEEPS  = DEF_MIN_BEEPS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] req,
  output logic       tone_out,
  output logic [1:0] chan,
  output logic [3:0] beep_cnt,
  output logic       busy
);

  localparam int TMAX12 = (TONE1_HALF > TONE2_HALF) ? TONE1_HALF : TONE2_HALF;
  localparam int TMAX   = (TMAX12 > TONE3_HALF) ? TMAX12 : TONE3_HALF;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int PMAX   = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
  localparam int PW     = $clog2(PMAX + 1);

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [1:0]    chan_q, chan_d;
  logic [3:0]    beep_cnt_q, beep_cnt_d;
  logic          busy_q, busy_d;

  logic [TW-1:0] half;
  logic          div_en, div_clr;
  logic [1:0]    win;
  logic          any_req, min_done, on_last, off_last;

  assign win      = win_chan(req);
  assign any_req  = |req;
  assign min_done = (beep_cnt_q >= 4'(MIN_BEEPS));
  assign on_last  = (phase_q == PW'(BEEP_ON - 1));
  assign off_last = (phase_q == PW'(BEEP_OFF - 1));

  always_comb begin
    case (chan_q)
      CH2:     half = TW'(TONE2_HALF);
      CH3:     half = TW'(TONE3_HALF);
      default: half = TW'(TONE1_HALF);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    chan_d     = chan_q;
    beep_cnt_d = beep_cnt_q;
    div_en     = 1'b0;
    div_clr    = 1'b0;
    if (ena) begin
      case (state_q)
        IDLE: begin
          div_clr = 1'b1;
          phase_d = '0;
          if (any_req) begin
            chan_d     = win;
            beep_cnt_d = 4'd0;
            state_d    = ON;
          end
        end
        ON: begin
          if (on_last) begin
            // Silence the pin and restart the divider so each beep starts
            // from a clean low phase.
            div_clr    = 1'b1;
            phase_d    = '0;
            beep_cnt_d = (beep_cnt_q == 4'd15) ? 4'd15 : beep_cnt_q + 4'd1;
            state_d    = OFF;
          end else begin
            div_en  = 1'b1;
            phase_d = phase_q + PW'(1);
          end
        end
        OFF: begin
          div_clr = 1'b1;
          if (off_last) begin
            phase_d = '0;
            state_d = ON;
            // Only place besides IDLE where requests are looked at. A
            // different winner takes over only once the minimum alert has
            // completed; otherwise the current channel keeps beeping.
            if (any_req && (win != chan_q) && min_done) begin
              chan_d     = win;
              beep_cnt_d = 4'd0;
            end else if (!any_req && min_done) begin
              chan_d     = CH_NONE;
              beep_cnt_d = 4'd0;
              state_d    = IDLE;
            end
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          chan_d  = CH_NONE;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      chan_q     <= CH_NONE;
      beep_cnt_q <= 4'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      chan_q     <= chan_d;
      beep_cnt_q <= beep_cnt_d;
      busy_q     <= busy_d;
    end
  end

  tone_divider #(.CW(TW)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (div_en),
    .clr      (div_clr),
    .half     (half),
    .tone_out (tone_out)
  );

  assign chan     = chan_q;
  assign beep_cnt = beep_cnt_q;
  assign busy     = busy_q;

endmodule

// File: doc/buzzer_tone_gen.md
# buzzer_tone_gen

Downstream output stage of the alarm path: consumes the three level-type buzzer requests from the sensor/alarm stage and drives a single piezo pin with a channel-specific square-wave pitch, gated into an on/off beep cadence. Guarantees a minimum audible alert length even for short requests and arbitrates simultaneous requests by fixed priority. Its outputs go to the top-level pins.

## Interface
- TONE1_HALF, 12: half-period of channel 1 tone, clk cycles (≥2)
- TONE2_HALF, 8: half-period of channel 2 tone
- TONE3_HALF, 5: half-period of channel 3 tone
- BEEP_ON, 64: beep on-time, clk cycles (≥2)
- BEEP_OFF, 32: gap between beeps, clk cycles (≥2)
- MIN_BEEPS, 2: beeps completed per alert regardless of request duration (1..15)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  clock enable; low freezes all state
- req  in  3  buzzer requests; req[0]=channel 1 … req[2]=channel 3
- tone_out  out  1  square wave to piezo
- chan  out  2  latched channel (0 = none, 1..3)
- beep_cnt  out  4  completed beeps in current alert, saturates at 15
- busy  out  1  high whenever state ≠ IDLE

## Operation
- Reset: state IDLE, tone_out=0, chan=0, beep_cnt=0, busy=0, all counters 0.
- ena=0: state, counters, outputs hold; no request sampled.
- Priority: highest set index wins (req[2] > req[1] > req[0]).
- FSM states IDLE, ON, OFF:
  - IDLE: if any req, latch chan = winning index+1, beep_cnt=0, phase and tone counters 0, tone_out=0 → ON.
  - ON: tone counter counts 0..HALF(chan)-1; at HALF-1 it wraps and tone_out toggles. Phase counter counts 0..BEEP_ON-1; at BEEP_ON-1: tone_out←0, tone counter←0, beep_cnt+1 (saturating) → OFF.
  - OFF: tone_out=0; phase counter 0..BEEP_OFF-1; at BEEP_OFF-1 re-arbitrate using the incremented beep_cnt:
    - any req set and winner = chan → ON, beep_cnt continues;
    - any req set, winner ≠ chan, beep_cnt ≥ MIN_BEEPS → latch new chan, beep_cnt=0 → ON;
    - any req set, winner ≠ chan, beep_cnt < MIN_BEEPS → same chan → ON (preemption deferred);
    - no req, beep_cnt < MIN_BEEPS → ON, same chan;
    - no req, beep_cnt ≥ MIN_BEEPS → IDLE, chan=0, beep_cnt=0.
- Requests are never acted on mid-beep; arbitration only in IDLE and at end of OFF.
- Counter widths sized by $clog2 of the largest parameter; no overflow possible within legal ranges.

## Timing
- All outputs registered.
- req asserted in IDLE at edge N: busy=1, chan valid after edge N; first tone_out rise after edge N+HALF.
- Beep period BEEP_ON+BEEP_OFF cycles; ON→OFF and OFF→ON transitions take effect on the edge after the terminal count.
- Minimum alert: MIN_BEEPS×(BEEP_ON+BEEP_OFF) cycles of busy.
- Asynchronous reset mid-beep: tone_out drops immediately, alert discarded.

## Structure
- Package buzzer_pkg: state enum (IDLE/ON/OFF), channel codes CH_NONE..CH3, default parameter constants shared with the alarm stage.
- Sub-module tone_divider: half-period counter plus toggle flop with sync clear and enable; one instance, HALF selected by mux on chan.

## Test plan
- Reset values: rst_n low → tone_out=0, chan=0, beep_cnt=0, busy=0; assert rst_n low mid-ON → outputs return to reset values immediately.
- 1-cycle req=3'b001, defaults → chan=1; two beeps, 5 tone_out toggles each (every 12 cycles); busy high exactly 192 cycles; beep_cnt 1 then 2; then IDLE.
- req=3'b100 held 500 cycles → chan=3, toggles every 5 cycles; beeps continue until first OFF end after release; beep_cnt counts 1..n.
- req=3'b101 simultaneously → chan=3 (priority); drop req[2] after 1 beep keeping req[0] → second beep still channel 3, then chan switches to 1 with beep_cnt=0.
- req=3'b001 held, req[1] asserted during beep 1 → switch to chan=2 only at end of beep 2's OFF.
- ena low for 40 cycles mid-ON → tone_out, counters, beep_cnt frozen; alert resumes and total busy extends by exactly 40 cycles.
